// File: rtl/instr_executor_pkg.sv
// Shared types for the execution stage behind instr_register: opcodes,
// instruction/result formats and the executor state encoding.
package instr_executor_pkg;

  localparam int PTR_W       = 5;
  localparam int OP_W        = 32;
  localparam int RES_W       = 64;
  localparam int DIV_LATENCY = 33;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [RES_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    DIV_WAIT = 3'd3,
    RESULT   = 3'd4
  } exec_state_t;

  function automatic result_t sext(input operand_t v);
    return result_t'(v);
  endfunction

endpackage

// File: rtl/instr_executor_if.sv
// Register-read port and result channel of the executor.
// Result channel: a transfer happens on a rising edge where res_valid and
// res_ready are both high; while res_valid waits for res_ready, all res_*
// fields and result stay frozen and res_valid does not drop.
interface instr_executor_if;
  import instr_executor_pkg::*;

  logic [PTR_W-1:0] read_pointer;
  instruction_t     instruction_word;
  logic             res_valid;
  logic             res_ready;
  logic [PTR_W-1:0] res_pointer;
  opcode_t          res_opcode;
  result_t          result;
  logic             div_by_zero;

  modport master (
    output read_pointer,
    input  instruction_word,
    output res_valid,
    input  res_ready,
    output res_pointer,
    output res_opcode,
    output result,
    output div_by_zero
  );

  modport slave (
    input  read_pointer,
    output instruction_word,
    input  res_valid,
    output res_ready,
    input  res_pointer,
    input  res_opcode,
    input  result,
    input  div_by_zero
  );

endinterface

// File: rtl/instr_executor_divider.sv
// Signed 32-bit restoring divider: 32 magnitude iterations, then a cycle in
// which div_done is high and the sign-corrected quotient/remainder are valid.
module instr_divider
  import instr_executor_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   div_start,
  input  operand_t               dividend,
  input  operand_t               divisor,
  output logic signed [OP_W:0]   quotient,
  output logic signed [OP_W:0]   remainder,
  output logic                   div_done
);

  logic [OP_W-1:0] dvd_q;
  logic [OP_W-1:0] dsr_q;
  logic [OP_W-1:0] rem_q;
  logic            neg_quo;
  logic            neg_rem;
  logic            running;
  logic            fixup;
  logic [5:0]      count;
  logic [OP_W:0]   rem_sh;
  logic [OP_W:0]   diff;
  logic [OP_W:0]   quo_mag;
  logic [OP_W:0]   rem_mag;

  function automatic logic [OP_W-1:0] mag(input operand_t v);
    return v[OP_W-1] ? OP_W'(-v) : OP_W'(v);
  endfunction

  // dvd_q shifts the dividend out at the top and collects quotient bits at the bottom.
  always_comb begin
    rem_sh = {rem_q, dvd_q[OP_W-1]};
    diff   = rem_sh - {1'b0, dsr_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      running <= 1'b0;
      fixup   <= 1'b0;
      count   <= '0;
    end else if (div_start) begin
      dvd_q   <= mag(dividend);
      dsr_q   <= mag(divisor);
      rem_q   <= '0;
      neg_quo <= dividend[OP_W-1] ^ divisor[OP_W-1];
      neg_rem <= dividend[OP_W-1];
      running <= 1'b1;
      fixup   <= 1'b0;
      count   <= '0;
    end else if (running) begin
      if (!diff[OP_W]) begin
        rem_q <= diff[OP_W-1:0];
        dvd_q <= {dvd_q[OP_W-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[OP_W-1:0];
        dvd_q <= {dvd_q[OP_W-2:0], 1'b0};
      end
      count <= count + 1'b1;
      if (count == 6'(DIV_LATENCY - 2)) begin
        running <= 1'b0;
        fixup   <= 1'b1;
      end
    end else begin
      fixup <= 1'b0;
    end
  end

  // 33-bit outputs so -2^31 / -1 = +2^31 is representable.
  always_comb begin
    quo_mag   = {1'b0, dvd_q};
    rem_mag   = {1'b0, rem_q};
    quotient  = neg_quo ? -quo_mag : quo_mag;
    remainder = neg_rem ? -rem_mag : rem_mag;
  end

  assign div_done = fixup;

endmodule

// File: rtl/instr_executor.sv
// Execution stage: walks first..last (wrapping mod 32) through instr_register,
// executes each instruction and offers the result on the valid/ready channel.
module instr_executor
  import instr_executor_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PTR_W-1:0]   first_ptr,
  input  logic [PTR_W-1:0]   last_ptr,
  instr_executor_if.master   bus,
  output logic               busy,
  output logic               done,
  output exec_state_t        state
);

  exec_state_t      state_q;
  exec_state_t      state_d;
  instruction_t     instr_q;
  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] res_ptr_q;
  opcode_t          res_opc_q;
  result_t          res_q;
  logic             dbz_q;
  logic             done_q;

  logic                  div_start;
  logic                  div_done;
  logic signed [OP_W:0]  quotient;
  logic signed [OP_W:0]  remainder;

  logic    is_div;
  logic    zero_div;
  logic    handshake;
  logic    last_hit;
  logic    load_res;
  logic    dbz_d;
  result_t a64;
  result_t b64;
  result_t exec_val;
  result_t res_d;

  instr_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (instr_q.op_a),
    .divisor   (instr_q.op_b),
    .quotient  (quotient),
    .remainder (remainder),
    .div_done  (div_done)
  );

  always_comb begin
    a64      = sext(instr_q.op_a);
    b64      = sext(instr_q.op_b);
    is_div   = (instr_q.opc == DIV) || (instr_q.opc == MOD);
    zero_div = (instr_q.op_b == '0);
    case (instr_q.opc)
      PASSA:   exec_val = a64;
      PASSB:   exec_val = b64;
      ADD:     exec_val = a64 + b64;
      SUB:     exec_val = a64 - b64;
      MULT:    exec_val = a64 * b64;
      default: exec_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    load_res  = 1'b0;
    res_d     = '0;
    dbz_d     = 1'b0;
    handshake = (state_q == RESULT) && bus.res_ready;
    last_hit  = (rd_ptr_q == last_q);
    case (state_q)
      IDLE:     if (start) state_d = FETCH;
      FETCH:    state_d = EXEC;
      EXEC: begin
        if (is_div && !zero_div) begin
          div_start = 1'b1;
          state_d   = DIV_WAIT;
        end else begin
          // Divide by zero falls through here: exec_val is 0 for DIV/MOD.
          state_d  = RESULT;
          load_res = 1'b1;
          res_d    = exec_val;
          dbz_d    = is_div;
        end
      end
      DIV_WAIT: begin
        if (div_done) begin
          state_d  = RESULT;
          load_res = 1'b1;
          res_d    = (instr_q.opc == DIV) ? RES_W'(quotient) : RES_W'(remainder);
        end
      end
      RESULT:   if (handshake) state_d = last_hit ? IDLE : FETCH;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      last_q    <= '0;
      rd_ptr_q  <= '0;
      res_ptr_q <= '0;
      res_opc_q <= ZERO;
      res_q     <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == IDLE && start) begin
        last_q   <= last_ptr;
        rd_ptr_q <= first_ptr;
      end
      if (state_q == FETCH) instr_q <= bus.instruction_word;
      if (load_res) begin
        res_q     <= res_d;
        res_ptr_q <= rd_ptr_q;
        res_opc_q <= instr_q.opc;
        dbz_q     <= dbz_d;
      end
      if (handshake) begin
        if (last_hit) done_q   <= 1'b1;
        else          rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign bus.read_pointer = rd_ptr_q;
  assign bus.res_valid    = (state_q == RESULT);
  assign bus.res_pointer  = res_ptr_q;
  assign bus.res_opcode   = res_opc_q;
  assign bus.result       = res_q;
  assign bus.div_by_zero  = dbz_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign state            = state_q;

endmodule

// File: tb/tb_instr_executor.sv
// Bench for instr_executor: vector table, random run and hand-written
// sequences for latency, wrap/backpressure and reset during a divide.
module tb_instr_executor;
  import instr_executor_pkg::*;

  typedef logic [73:0] sb_t;  // {pointer[5], opcode[4], div_by_zero, result[64]}

  typedef struct {
    opcode_t  opc;
    operand_t a;
    operand_t b;
    result_t  exp_res;
    logic     exp_dbz;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_ptr;
  logic [4:0]  last_ptr;
  logic        busy;
  logic        done;
  exec_state_t state;

  instruction_t mem [32];
  sb_t          exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           done_cnt = 0;
  logic         rnd_ready = 1'b0;
  vec_t         tbl [16];

  instr_executor_if bus ();
  assign bus.instruction_word = mem[bus.read_pointer];

  instr_executor dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_ptr (first_ptr),
    .last_ptr  (last_ptr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  task automatic push_exp(input logic [4:0] ptr, input opcode_t opc, input logic dbz, input result_t res);
    exp_q.push_back({ptr, opc, dbz, res});
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (done) done_cnt++;
    if (!reset && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got result from pointer %0d, expected none", bus.res_pointer);
      end else begin
        e = exp_q.pop_front();
        check("sb_pointer", 64'(bus.res_pointer), 64'(e[73:69]));
        check("sb_opcode",  64'(bus.res_opcode),  64'(e[68:65]));
        check("sb_dbz",     64'(bus.div_by_zero), 64'(e[64]));
        check("sb_result",  bus.result,           e[63:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic result_t model(input opcode_t opc, input operand_t a, input operand_t b,
                                    output logic dbz);
    longint la = a;
    longint lb = b;
    dbz = 1'b0;
    case (opc)
      PASSA:   return la;
      PASSB:   return lb;
      ADD:     return la + lb;
      SUB:     return la - lb;
      MULT:    return la * lb;
      DIV:     begin if (lb == 0) begin dbz = 1'b1; return 0; end return la / lb; end
      MOD:     begin if (lb == 0) begin dbz = 1'b1; return 0; end return la % lb; end
      default: return 0;
    endcase
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [4:0] f, input logic [4:0] l);
    first_ptr = f;
    last_ptr  = l;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic measure_latency(input string name, input int exp_lat);
    int k;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.res_valid) break;
    end
    check(name, 64'(k), 64'(exp_lat));
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    n_checks++;
    if (k == budget) begin
      n_errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] wp [4];
    result_t    wr [4];
    int         d0;
    int         k;
    opcode_t    ro;
    operand_t   ra;
    operand_t   rb;
    result_t    rr;
    logic       rd;

    tbl[0]  = '{MULT,  32'h7FFFFFFF, 32'd2,        64'h00000000FFFFFFFE, 1'b0};
    tbl[1]  = '{DIV,   -32'sd15,     32'sd4,       -64'sd3,              1'b0};
    tbl[2]  = '{MOD,   -32'sd15,     32'sd4,       -64'sd3,              1'b0};
    tbl[3]  = '{DIV,   32'sd9,       32'sd0,       64'sd0,               1'b1};
    tbl[4]  = '{ADD,   -32'sd7,      32'sd5,       -64'sd2,              1'b0};
    tbl[5]  = '{SUB,   32'h80000000, 32'sd1,       64'hFFFFFFFF7FFFFFFF, 1'b0};
    tbl[6]  = '{PASSA, -32'sd1,      32'sd3,       -64'sd1,              1'b0};
    tbl[7]  = '{PASSB, 32'sd4,       32'h12345678, 64'h0000000012345678, 1'b0};
    tbl[8]  = '{ZERO,  32'sd5,       32'sd6,       64'sd0,               1'b0};
    tbl[9]  = '{DIV,   32'h80000000, -32'sd1,      64'h0000000080000000, 1'b0};
    tbl[10] = '{MOD,   32'h80000000, -32'sd1,      64'sd0,               1'b0};
    tbl[11] = '{MULT,  32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0};
    tbl[12] = '{DIV,   32'sd7,       -32'sd2,      -64'sd3,              1'b0};
    tbl[13] = '{MOD,   32'sd7,       -32'sd2,      64'sd1,               1'b0};
    tbl[14] = '{MOD,   32'sd5,       32'sd0,       64'sd0,               1'b1};
    tbl[15] = '{ADD,   32'h7FFFFFFF, 32'h7FFFFFFF, 64'h00000000FFFFFFFE, 1'b0};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset         = 1'b1;
    start         = 1'b1;
    first_ptr     = '0;
    last_ptr      = '0;
    bus.res_ready = 1'b0;

    // reset held two cycles with start high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",        64'(state),           64'(IDLE));
    check("rst_busy",         64'(busy),            64'd0);
    check("rst_done",         64'(done),            64'd0);
    check("rst_res_valid",    64'(bus.res_valid),   64'd0);
    check("rst_read_pointer", 64'(bus.read_pointer), 64'd0);
    check("rst_res_pointer",  64'(bus.res_pointer), 64'd0);
    check("rst_res_opcode",   64'(bus.res_opcode),  64'd0);
    check("rst_result",       bus.result,           64'd0);
    check("rst_dbz",          64'(bus.div_by_zero), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    reset = 1'b0;
    cyc(4);
    check("idle_busy",  64'(busy),          64'd0);
    check("idle_valid", 64'(bus.res_valid), 64'd0);
    bus.res_ready = 1'b1;

    // single ADD: valid three cycles after start, done one cycle after handshake
    mem[3] = '{ADD, -32'sd7, 32'sd5};
    push_exp(5'd3, ADD, 1'b0, -64'sd2);
    kick(5'd3, 5'd3);
    measure_latency("add_latency", 3);
    @(negedge clk);
    check("add_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("add_done_clear", 64'(done), 64'd0);
    check("add_busy_clear", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // divide by zero skips the divider
    mem[4] = '{DIV, 32'sd9, 32'sd0};
    push_exp(5'd4, DIV, 1'b1, 64'sd0);
    kick(5'd4, 5'd4);
    measure_latency("dbz_latency", 3);
    wait_done(10, "dbz");

    mem[6] = '{DIV, -32'sd15, 32'sd4};
    push_exp(5'd6, DIV, 1'b0, -64'sd3);
    kick(5'd6, 5'd6);
    measure_latency("div_latency", 36);
    wait_done(10, "div");

    // vector table over locations 0..15
    for (int i = 0; i < 16; i++) begin
      mem[i] = '{tbl[i].opc, tbl[i].a, tbl[i].b};
      push_exp(5'(i), tbl[i].opc, tbl[i].exp_dbz, tbl[i].exp_res);
    end
    kick(5'd0, 5'd15);
    wait_done(16 * 40 + 20, "table");

    // random operands with random backpressure
    for (int i = 10; i < 22; i++) begin
      ro = opcode_t'($urandom_range(0, 7));
      ra = operand_t'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? operand_t'($urandom_range(0, 2)) : operand_t'($urandom);
      mem[i] = '{ro, ra, rb};
      rr = model(ro, ra, rb, rd);
      push_exp(5'(i), ro, rd, rr);
    end
    rnd_ready = 1'b1;
    kick(5'd10, 5'd21);
    wait_done(3000, "random");
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 bus.res_ready = 1'b0;

    // wrap 30..1 with five stalled cycles per result
    mem[30] = '{PASSA, 32'sd100, 32'sd0};
    mem[31] = '{PASSB, 32'sd0,   -32'sd101};
    mem[0]  = '{SUB,   32'sd5,   32'sd7};
    mem[1]  = '{ADD,   32'sd1,   32'sd2};
    wp[0] = 5'd30; wr[0] = 64'sd100;
    wp[1] = 5'd31; wr[1] = -64'sd101;
    wp[2] = 5'd0;  wr[2] = -64'sd2;
    wp[3] = 5'd1;  wr[3] = 64'sd3;
    push_exp(5'd30, PASSA, 1'b0, wr[0]);
    push_exp(5'd31, PASSB, 1'b0, wr[1]);
    push_exp(5'd0,  SUB,   1'b0, wr[2]);
    push_exp(5'd1,  ADD,   1'b0, wr[3]);
    d0 = done_cnt;
    kick(5'd30, 5'd1);
    for (int i = 0; i < 4; i++) begin
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.res_valid) break;
      end
      check("wrap_valid_seen", 64'(bus.res_valid), 64'd1);
      repeat (5) begin
        @(negedge clk);
        check("stall_valid",   64'(bus.res_valid),   64'd1);
        check("stall_pointer", 64'(bus.res_pointer), 64'(wp[i]));
        check("stall_result",  bus.result,           wr[i]);
      end
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
    end
    cyc(3);
    check("wrap_done_count", 64'(done_cnt - d0), 64'd1);
    check("wrap_busy_clear", 64'(busy),          64'd0);
    bus.res_ready = 1'b1;

    // reset during DIV_WAIT discards the run
    mem[5] = '{DIV, 32'sd100, 32'sd7};
    d0 = done_cnt;
    kick(5'd5, 5'd5);
    cyc(10);
    check("mid_div_state", 64'(state), 64'(DIV_WAIT));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 64'(state),         64'(IDLE));
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_busy",  64'(busy),          64'd0);
    cyc(50);
    check("mid_rst_no_done",  64'(done_cnt - d0), 64'd0);
    check("mid_rst_no_valid", 64'(bus.res_valid), 64'd0);
    push_exp(5'd5, DIV, 1'b0, 64'sd14);
    kick(5'd5, 5'd5);
    measure_latency("div_after_reset_latency", 36);
    wait_done(10, "div_after_reset");

    cyc(2);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_executor.md
Name: instr_executor

Overview:
- Execution stage directly downstream of instr_register.
- Walks a programmed range of register locations by driving read_pointer and capturing the returned instruction_word.
- Executes each instruction: single-cycle ALU for most opcodes, iterative divider for DIV/MOD.
- Presents each result on a valid/ready output channel, tagged with its source location.

Parameters:
- PTR_W, 5, register-file address width (32 locations).
- OP_W, 32, operand width (signed).
- RES_W, 64, result width (signed; holds the full MULT product).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- first_ptr  in  PTR_W  first location to execute; latched on start.
- last_ptr  in  PTR_W  last location to execute; latched on start.
- read_pointer  out  PTR_W  address to instr_register.
- instruction_word  in  instruction_t  {opc[3:0], op_a[31:0], op_b[31:0]}; combinational read of read_pointer.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_pointer  out  PTR_W  location the result came from.
- res_opcode  out  4  opcode executed.
- result  out  RES_W  signed result.
- div_by_zero  out  1  DIV/MOD with op_b==0; valid with res_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset: state=IDLE. read_pointer, res_pointer, res_opcode, result = 0. res_valid, div_by_zero, busy, done = 0. Divider aborted. Reset mid-run discards all work; no done pulse.
- IDLE:
  - On start=1: latch first/last, read_pointer<=first_ptr, go to FETCH.
  - start while not IDLE is ignored.
- FETCH: register instruction_word into an internal instruction register; go to EXEC.
- EXEC, by opcode:
  - ZERO -> 0.
  - PASSA -> sext(op_a).
  - PASSB -> sext(op_b).
  - ADD / SUB -> sext(op_a) ± sext(op_b), 64-bit, no overflow.
  - MULT -> full signed 64-bit product.
  - DIV / MOD with op_b != 0: pulse div_start, go to DIV_WAIT.
  - DIV / MOD with op_b == 0: result=0, div_by_zero=1, go to RESULT.
  - Any other opcode goes to RESULT.
- DIV_WAIT: wait for div_done (exactly 33 cycles after div_start).
  - DIV: quotient, truncated toward zero.
  - MOD: remainder, sign follows dividend.
  - -2^31 / -1 = +2^31 (fits in RES_W).
  - Go to RESULT.
- RESULT:
  - res_valid=1. result, res_pointer, res_opcode, div_by_zero are stable until handshake (res_valid & res_ready).
  - On handshake with pointer==last: res_valid<=0, done pulse next cycle, go to IDLE.
  - On handshake otherwise: read_pointer<=read_pointer+1 (mod 32, wraps 31->0), go to FETCH.
  - res_ready low: hold indefinitely.
- Latency (start sampled at cycle t, res_ready=1):
  - Non-divide: res_valid at t+3; next result every 3 cycles.
  - Divide: res_valid at t+36.
- Range rules:
  - first==last: exactly one instruction.
  - last<first: wraps through 31 to 0.
  - first=0, last=31: all 32 locations.
- Result registers update only on entry to RESULT.

Decomposition:
- instr_register_pkg (shared) additions: opcode_t (ZERO=0, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD=7), operand_t, instruction_t, result_t (signed 64), exec_state_t {IDLE, FETCH, EXEC, DIV_WAIT, RESULT}, DIV_LATENCY=33.
- Sub-module instr_divider: signed 32-bit iterative restoring divider.
  - Ports: clk, reset, div_start, dividend, divisor, quotient, remainder, div_done.
  - One bit per cycle plus sign fix-up cycle.

Test Plan:
- Reset sequence: assert reset 2 cycles with start=1 -> all outputs 0, busy=0, no result issued.
- ADD single op: loc 3={ADD,-7,5}, first=last=3, res_ready=1 -> res_valid at t+3, result=-2, res_pointer=3, done one cycle after handshake.
- MULT/DIV/MOD mix: loc0={MULT,0x7FFFFFFF,2}, loc1={DIV,-15,4}, loc2={MOD,-15,4} -> results 0xFFFFFFFE, -3, -3; DIV result at t+36 relative to its fetch.
- Divide by zero: {DIV,9,0} -> result=0, div_by_zero=1, no DIV_WAIT cycles.
- Wrap + backpressure: first=30, last=1, res_ready low 5 cycles on each result -> pointers 30,31,0,1 in order, outputs stable while stalled, one done pulse.
- Reset mid-divide: reset during DIV_WAIT -> IDLE next cycle, res_valid=0, no done; a new start then runs normally.
